// File: rtl/obstacle_scroller.sv
// obstacle_scroller
//   Manages NUM_OBS independently scrolling ground obstacles: pseudo-random
//   spawn spacing, per-frame motion, sprite ROM addressing for the pixel
//   currently being drawn, score counting and a sticky dino/obstacle
//   collision flag. Runs on the system clock; pix_en qualifies pixel work.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   pix_en            one-cycle pixel strobe
//   screen_end        one-cycle frame-boundary pulse
//   active, x, y      timing-generator active flag and pixel coordinates
//   run, clear        game running / restart game
//   speed             pixels moved per frame
//   dino_px           dino opaque at the pixel presented last pix_en
//   obs_opaque        sprite ROM data for obs_addr (one pix_en later)
//   obs_pixel         registered pixel lies inside an obstacle box
//   obs_addr, obs_id  sprite ROM address and covering slot index
//   collision         sticky collision flag
//   score             obstacles passed, saturating
module obstacle_scroller #(
    parameter int NUM_OBS        = 3,
    parameter int OBS_W          = 49,
    parameter int OBS_H          = 80,
    parameter int GROUND         = 335,
    parameter int X_SPAWN        = 640,
    parameter int MIN_GAP_FRAMES = 40,
    parameter int ADDR_W         = 13,
    parameter int SCORE_W        = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_en,
    input  logic               screen_end,
    input  logic               active,
    input  logic [9:0]         x,
    input  logic [8:0]         y,
    input  logic               run,
    input  logic               clear,
    input  logic [3:0]         speed,
    input  logic               dino_px,
    input  logic               obs_opaque,
    output logic               obs_pixel,
    output logic [ADDR_W-1:0]  obs_addr,
    output logic [2:0]         obs_id,
    output logic               collision,
    output logic [SCORE_W-1:0] score
);

    localparam int          CNT_W   = $clog2(MIN_GAP_FRAMES + 64);
    localparam logic [10:0] TOP_ROW = 11'(GROUND - OBS_H);
    localparam logic [10:0] BOT_ROW = 11'(GROUND);
    localparam logic [10:0] BOX_W   = 11'(OBS_W);
    localparam logic [10:0] R_SPAWN = 11'(X_SPAWN + OBS_W);

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [3:0] n);
        logic [SCORE_W:0] s;
        s = {1'b0, a} + (SCORE_W+1)'(n);
        return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] sprite_addr(input logic [10:0] row,
                                                      input logic [10:0] col);
        logic [31:0] a;
        a = 32'(row) * 32'(OBS_W) + 32'(col);
        return a[ADDR_W-1:0];
    endfunction

    logic [15:0]        lfsr_q, lfsr_d;
    logic [NUM_OBS-1:0] valid_q, valid_d;
    logic [10:0]        r_q [NUM_OBS];
    logic [10:0]        r_d [NUM_OBS];
    logic [CNT_W-1:0]   spawn_cnt_q, spawn_cnt_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               collision_q, collision_d;
    logic               obs_pixel_q, obs_pixel_d;
    logic [ADDR_W-1:0]  obs_addr_q, obs_addr_d;
    logic [2:0]         obs_id_q, obs_id_d;

    logic               frame_upd;
    logic               spawned;
    logic [3:0]         retire_cnt;
    logic [10:0]        x11, y11;
    logic               in_rows;
    logic               hit;
    logic [2:0]         hit_idx;
    logic [10:0]        hit_r;

    assign lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign frame_upd = screen_end & run & ~collision_q;

    // Frame update: motion/retire on slots valid before the update, then spawn
    // into the lowest slot that was free before it (so a retiree waits a frame).
    always_comb begin
        valid_d     = valid_q;
        r_d         = r_q;
        spawn_cnt_d = spawn_cnt_q;
        score_d     = score_q;
        retire_cnt  = 4'd0;
        spawned     = 1'b0;
        if (frame_upd) begin
            for (int i = 0; i < NUM_OBS; i++) begin
                if (valid_q[i]) begin
                    if (r_q[i] <= {7'd0, speed}) begin
                        valid_d[i] = 1'b0;
                        retire_cnt = retire_cnt + 4'd1;
                    end else begin
                        r_d[i] = r_q[i] - {7'd0, speed};
                    end
                end
            end
            if (spawn_cnt_q != '0) begin
                spawn_cnt_d = spawn_cnt_q - 1'b1;
            end else begin
                for (int i = 0; i < NUM_OBS; i++) begin
                    if (!valid_q[i] && !spawned) begin
                        valid_d[i] = 1'b1;
                        r_d[i]     = R_SPAWN;
                        spawned    = 1'b1;
                    end
                end
                // No free slot: the counter stays at zero and retries next frame.
                if (spawned) begin
                    spawn_cnt_d = CNT_W'(MIN_GAP_FRAMES) + CNT_W'(lfsr_q[5:0]);
                end
            end
            score_d = sat_add(score_q, retire_cnt);
        end
    end

    // Pixel path: box test done at 11 bits as x < r and x+OBS_W >= r so a box
    // hanging off the left edge never needs r-OBS_W to be formed.
    always_comb begin
        x11     = {1'b0, x};
        y11     = {2'b00, y};
        in_rows = (y11 >= TOP_ROW) && (y11 < BOT_ROW);
        hit     = 1'b0;
        hit_idx = 3'd0;
        hit_r   = 11'd0;
        for (int i = 0; i < NUM_OBS; i++) begin
            if (!hit && valid_q[i] && in_rows && (x11 < r_q[i]) && ((x11 + BOX_W) >= r_q[i])) begin
                hit     = 1'b1;
                hit_idx = 3'(i);
                hit_r   = r_q[i];
            end
        end
        obs_pixel_d = obs_pixel_q;
        obs_addr_d  = obs_addr_q;
        obs_id_d    = obs_id_q;
        collision_d = collision_q;
        if (pix_en) begin
            obs_pixel_d = active & hit;
            if (active && hit) begin
                obs_id_d   = hit_idx;
                obs_addr_d = sprite_addr(y11 - TOP_ROW, x11 + BOX_W - hit_r);
            end
            // obs_opaque belongs to the address registered on the previous strobe.
            if (dino_px && obs_opaque && obs_pixel_q) begin
                collision_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            lfsr_q      <= reset ? 16'hACE1 : lfsr_d;
            valid_q     <= '0;
            spawn_cnt_q <= '0;
            score_q     <= '0;
            collision_q <= 1'b0;
            obs_pixel_q <= 1'b0;
            obs_addr_q  <= '0;
            obs_id_q    <= 3'd0;
        end else begin
            lfsr_q      <= lfsr_d;
            valid_q     <= valid_d;
            spawn_cnt_q <= spawn_cnt_d;
            score_q     <= score_d;
            collision_q <= collision_d;
            obs_pixel_q <= obs_pixel_d;
            obs_addr_q  <= obs_addr_d;
            obs_id_q    <= obs_id_d;
        end
    end

    // Positions are meaningless while a slot is invalid, so they skip reset.
    always_ff @(posedge clk) begin
        if (!reset && !clear) begin
            r_q <= r_d;
        end
    end

    assign obs_pixel = obs_pixel_q;
    assign obs_addr  = obs_addr_q;
    assign obs_id    = obs_id_q;
    assign collision = collision_q;
    assign score     = score_q;

endmodule

// File: tb/tb_obstacle_scroller.sv
// Bench for obstacle_scroller: pixel outputs go through an expectation queue,
// frame/state behaviour is checked inline by each scenario task.
module tb_obstacle_scroller;

    logic        clk = 1'b0;
    logic        reset = 1'b1, pix_en = 1'b0, screen_end = 1'b0, active = 1'b0;
    logic        run = 1'b0, clear = 1'b0, dino_px = 1'b0, obs_opaque = 1'b0;
    logic [9:0]  x = 10'd0;
    logic [8:0]  y = 9'd0;
    logic [3:0]  speed = 4'd0;
    logic        obs_pixel;
    logic [12:0] obs_addr;
    logic [2:0]  obs_id;
    logic        collision;
    logic [15:0] score;

    always #5 clk = ~clk;

    obstacle_scroller dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .screen_end(screen_end),
        .active(active), .x(x), .y(y), .run(run), .clear(clear), .speed(speed),
        .dino_px(dino_px), .obs_opaque(obs_opaque), .obs_pixel(obs_pixel),
        .obs_addr(obs_addr), .obs_id(obs_id), .collision(collision), .score(score)
    );

    typedef struct {
        logic        pix;
        logic [12:0] addr;
        logic [2:0]  id;
    } exp_t;

    int          tests = 0;
    int          fails = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [12:0] last_addr = 13'd0;
    logic [2:0]  last_id = 3'd0;
    logic        chk_q = 1'b0;
    logic [15:0] m_lfsr = 16'h0000;

    // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, seeded only by reset.
    always @(posedge clk) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    always @(posedge clk) chk_q <= pix_en;

    always @(negedge clk) begin
        if (chk_q) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL pix_queue: output strobe with no expectation queued");
            end else begin
                mon_e = sb.pop_front();
                if (obs_pixel !== mon_e.pix || obs_addr !== mon_e.addr || obs_id !== mon_e.id) begin
                    fails++;
                    $display("FAIL pix_out: got pix=%0d addr=%0d id=%0d expected pix=%0d addr=%0d id=%0d",
                             obs_pixel, obs_addr, obs_id, mon_e.pix, mon_e.addr, mon_e.id);
                end
            end
        end
    end

    function automatic logic [12:0] f_addr(input int xv, input int yv, input int rv);
        return 13'((yv - 255) * 49 + (xv + 49 - rv));
    endfunction

    task automatic drive_pix(input int xv, input int yv, input logic act, input logic dino,
                             input logic opq, input logic hitv, input int rv);
        exp_t e;
        if (hitv) begin
            last_addr = f_addr(xv, yv, rv);
            last_id   = 3'd0;
        end
        e.pix  = hitv;
        e.addr = last_addr;
        e.id   = last_id;
        @(negedge clk);
        x = 10'(xv); y = 9'(yv); active = act; dino_px = dino; obs_opaque = opq;
        pix_en = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        pix_en = 1'b0; dino_px = 1'b0; obs_opaque = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) screen_end = 1'b1;
            @(negedge clk) screen_end = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; run = 1'b0; speed = 4'd0;
        @(negedge clk);
        reset = 1'b0;
        last_addr = 13'd0; last_id = 3'd0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (obs_pixel !== 1'b0) begin fails++; $display("FAIL rst_pixel: got %0d expected 0", obs_pixel); end
        tests++; if (obs_addr !== 13'd0) begin fails++; $display("FAIL rst_addr: got %0d expected 0", obs_addr); end
        tests++; if (obs_id !== 3'd0) begin fails++; $display("FAIL rst_id: got %0d expected 0", obs_id); end
        tests++; if (collision !== 1'b0) begin fails++; $display("FAIL rst_coll: got %0d expected 0", collision); end
        tests++; if (score !== 16'd0) begin fails++; $display("FAIL rst_score: got %0d expected 0", score); end
        tests++; if (dut.valid_q !== 3'b000) begin fails++; $display("FAIL rst_valid: got %b expected 000", dut.valid_q); end
        tests++; if (dut.lfsr_q !== 16'hACE1) begin fails++; $display("FAIL rst_lfsr: got %h expected ace1", dut.lfsr_q); end
    endtask

    task automatic test_spawn_retire();
        run = 1'b1; speed = 4'd4;
        frames(1);
        tests++; if (dut.valid_q[0] !== 1'b1) begin fails++; $display("FAIL spawn_valid: got %0d expected 1", dut.valid_q[0]); end
        tests++; if (dut.r_q[0] !== 11'd689) begin fails++; $display("FAIL spawn_r: got %0d expected 689", dut.r_q[0]); end
        frames(172);
        tests++; if (dut.r_q[0] !== 11'd1) begin fails++; $display("FAIL scroll_r: got %0d expected 1", dut.r_q[0]); end
        frames(1);
        tests++; if (dut.valid_q[0] !== 1'b0) begin fails++; $display("FAIL retire_valid: got %0d expected 0", dut.valid_q[0]); end
        tests++; if (score !== 16'd1) begin fails++; $display("FAIL retire_score: got %0d expected 1", score); end
    endtask

    task automatic test_pixel_box();
        do_reset();
        run = 1'b1; speed = 4'd4;
        frames(1);
        speed = 4'd15; frames(25);
        speed = 4'd14; frames(1);
        run = 1'b0;
        tests++; if (dut.r_q[0] !== 11'd300) begin fails++; $display("FAIL box_r: got %0d expected 300", dut.r_q[0]); end
        drive_pix(251, 255, 1'b1, 1'b0, 1'b0, 1'b1, 300);
        drive_pix(299, 334, 1'b1, 1'b0, 1'b0, 1'b1, 300);
        drive_pix(300, 255, 1'b1, 1'b0, 1'b0, 1'b0, 300);
        drive_pix(251, 254, 1'b1, 1'b0, 1'b0, 1'b0, 300);
        drive_pix(251, 335, 1'b1, 1'b0, 1'b0, 1'b0, 300);
        drive_pix(260, 300, 1'b0, 1'b0, 1'b0, 1'b0, 300);
    endtask

    task automatic test_off_left();
        run = 1'b1; speed = 4'd14;
        frames(20);
        run = 1'b0;
        tests++; if (dut.r_q[0] !== 11'd20) begin fails++; $display("FAIL left_r: got %0d expected 20", dut.r_q[0]); end
        drive_pix(0, 255, 1'b1, 1'b0, 1'b0, 1'b1, 20);
        drive_pix(20, 255, 1'b1, 1'b0, 1'b0, 1'b0, 20);
        drive_pix(19, 334, 1'b1, 1'b0, 1'b0, 1'b1, 20);
    endtask

    task automatic test_collision();
        drive_pix(30, 255, 1'b1, 1'b0, 1'b0, 1'b0, 20);
        drive_pix(5, 260, 1'b1, 1'b1, 1'b1, 1'b1, 20);
        tests++; if (collision !== 1'b0) begin fails++; $display("FAIL coll_noprev: got %0d expected 0", collision); end
        drive_pix(6, 260, 1'b1, 1'b1, 1'b0, 1'b1, 20);
        tests++; if (collision !== 1'b0) begin fails++; $display("FAIL coll_clear_px: got %0d expected 0", collision); end
        drive_pix(7, 260, 1'b1, 1'b1, 1'b1, 1'b1, 20);
        tests++; if (collision !== 1'b1) begin fails++; $display("FAIL coll_set: got %0d expected 1", collision); end
        run = 1'b1; speed = 4'd5;
        frames(10);
        tests++; if (dut.r_q[0] !== 11'd20) begin fails++; $display("FAIL coll_frozen_r: got %0d expected 20", dut.r_q[0]); end
        tests++; if (score !== 16'd0) begin fails++; $display("FAIL coll_score: got %0d expected 0", score); end
        tests++; if (collision !== 1'b1) begin fails++; $display("FAIL coll_sticky: got %0d expected 1", collision); end
        drive_pix(8, 260, 1'b1, 1'b0, 1'b0, 1'b1, 20);
        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
        last_addr = 13'd0; last_id = 3'd0;
        tests++; if (collision !== 1'b0) begin fails++; $display("FAIL clr_coll: got %0d expected 0", collision); end
        tests++; if ({obs_pixel, obs_addr, obs_id} !== 17'd0) begin fails++; $display("FAIL clr_pix: got %0d/%0d/%0d expected 0/0/0", obs_pixel, obs_addr, obs_id); end
        tests++; if (dut.valid_q !== 3'b000) begin fails++; $display("FAIL clr_valid: got %b expected 000", dut.valid_q); end
        tests++; if (dut.lfsr_q !== m_lfsr) begin fails++; $display("FAIL clr_lfsr: got %h expected %h", dut.lfsr_q, m_lfsr); end
        speed = 4'd4;
        frames(1);
        tests++; if (dut.r_q[0] !== 11'd689 || dut.valid_q[0] !== 1'b1) begin fails++; $display("FAIL clr_resume: got r=%0d v=%0d expected r=689 v=1", dut.r_q[0], dut.valid_q[0]); end
    endtask

    task automatic test_no_free_slot();
        logic [2:0] pv, nv;
        int last_sp, retires, spawns;
        do_reset();
        run = 1'b1; speed = 4'd0;
        frames(500);
        tests++; if (dut.valid_q !== 3'b111) begin fails++; $display("FAIL full_valid: got %b expected 111", dut.valid_q); end
        tests++; if (dut.spawn_cnt_q !== '0) begin fails++; $display("FAIL full_cnt: got %0d expected 0", dut.spawn_cnt_q); end
        tests++; if (score !== 16'd0) begin fails++; $display("FAIL full_score: got %0d expected 0", score); end
        speed = 4'd15;
        last_sp = -1; retires = 0; spawns = 0;
        for (int f = 0; f < 300; f++) begin
            pv = dut.valid_q;
            frames(1);
            nv = dut.valid_q;
            for (int s = 0; s < 3; s++) begin
                if (pv[s] && !nv[s]) retires++;
                if (!pv[s] && nv[s]) begin
                    spawns++;
                    if (last_sp >= 0) begin
                        tests++;
                        if (f - last_sp < 40) begin fails++; $display("FAIL spawn_gap: got %0d frames expected >= 40", f - last_sp); end
                    end
                    last_sp = f;
                end
            end
        end
        tests++; if (retires < 4) begin fails++; $display("FAIL retire_count: got %0d expected >= 4", retires); end
        tests++; if (spawns < 3) begin fails++; $display("FAIL respawn_count: got %0d expected >= 3", spawns); end
        tests++; if (score !== 16'(retires)) begin fails++; $display("FAIL retire_score: got %0d expected %0d", score, retires); end
    endtask

    task automatic test_reset_clear_priority();
        int n;
        do_reset();
        run = 1'b1; speed = 4'd15;
        n = 0;
        while (score < 16'd5 && n < 2000) begin
            frames(1);
            n++;
        end
        tests++; if (score !== 16'd5) begin fails++; $display("FAIL reach_score5: got %0d expected 5", score); end
        repeat (3) @(negedge clk);
        reset = 1'b1; clear = 1'b1; screen_end = 1'b1;
        @(negedge clk);
        reset = 1'b0; clear = 1'b0; screen_end = 1'b0;
        tests++; if (score !== 16'd0) begin fails++; $display("FAIL rc_score: got %0d expected 0", score); end
        tests++; if (dut.lfsr_q !== 16'hACE1) begin fails++; $display("FAIL rc_lfsr: got %h expected ace1", dut.lfsr_q); end
        tests++; if (dut.valid_q !== 3'b000) begin fails++; $display("FAIL rc_valid: got %b expected 000", dut.valid_q); end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_spawn_retire();
        test_pixel_box();
        test_off_left();
        test_collision();
        test_no_free_slot();
        test_reset_clear_priority();
        repeat (2) @(negedge clk);
        tests++; if (sb.size() != 0) begin fails++; $display("FAIL pix_leftover: got %0d queued expected 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
